rdyack_group_accum: RTL

// Downstream consumer stage for an 11-bit rdy/ack integer stream.

---
 rtl/rdyack_group_accum.sv | 105 ++++++++++
 1 files changed

// File: rtl/rdyack_group_accum.sv
// Groups an unsigned rdy/ack sample stream into {sum, count} records, buffered in a
// 2-entry output FIFO so accumulation proceeds while the downstream stage stalls.
module rdyack_group_accum #(
  parameter int IW    = 11,
  parameter int GROUP = 4,
  parameter int OW    = IW + $clog2(GROUP),
  parameter int CW    = $clog2(GROUP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          irdy,
  output logic          iack,
  input  logic [IW-1:0] iint,
  input  logic          ilast,
  output logic          ordy,
  input  logic          oack,
  output logic [OW-1:0] osum,
  output logic [CW-1:0] ocnt
);

  logic [OW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_fcount;
  logic [OW-1:0] r_hsum, r_tsum;
  logic [CW-1:0] r_hcnt, r_tcnt;

  logic          w_closing;
  logic          w_push;
  logic          w_pop;
  logic [OW-1:0] w_sum;
  logic [CW-1:0] w_cnt;

  always_comb begin
    w_sum     = r_acc + OW'(iint);
    w_cnt     = r_cnt + CW'(1);
    w_closing = irdy && ((r_cnt == CW'(GROUP - 1)) || ilast);
    // Only closing beats need FIFO room; oack is deliberately not part of this term.
    iack      = irdy && rst && (!w_closing || (r_fcount != 2'd2));
    w_push    = iack && w_closing;
    w_pop     = (r_fcount != 2'd0) && oack;
  end

  assign ordy = (r_fcount != 2'd0);
  assign osum = r_hsum;
  assign ocnt = r_hcnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (iack) begin
      if (w_closing) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= w_cnt;
      end
    end
  end

  // Head entry drives the outputs directly; the tail shifts into the head on a pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fcount <= '0;
      r_hsum   <= '0;
      r_hcnt   <= '0;
      r_tsum   <= '0;
      r_tcnt   <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_fcount == 2'd0) begin
            r_hsum <= w_sum;
            r_hcnt <= w_cnt;
          end else begin
            r_tsum <= w_sum;
            r_tcnt <= w_cnt;
          end
          r_fcount <= r_fcount + 2'd1;
        end
        2'b01: begin
          if (r_fcount == 2'd2) begin
            r_hsum <= r_tsum;
            r_hcnt <= r_tcnt;
          end
          r_fcount <= r_fcount - 2'd1;
        end
        2'b11: begin
          if (r_fcount == 2'd1) begin
            r_hsum <= w_sum;
            r_hcnt <= w_cnt;
          end else begin
            r_hsum <= r_tsum;
            r_hcnt <= r_tcnt;
            r_tsum <= w_sum;
            r_tcnt <= w_cnt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
